// File: rtl/write_back_arbiter.sv
// -----------------------------------------------------------------------------
// write_back_arbiter
//
// Collects results from NUM_UNITS execution units and serialises them onto the
// single register-file write-back port. Every unit owns a small FIFO with a
// valid/ready handshake. A round-robin arbiter pops at most one FIFO head per
// cycle and drives the registered write-back outputs.
//
// Ports:
//   clk                         system clock, rising-edge
//   rst                         synchronous, active-high reset
//   unit_valid_input[u]         unit u presents a result this cycle
//   unit_ready_output[u]        FIFO u can accept (registered count, not full)
//   unit_register_input         packed descriptors, slice u = [u*W +: W]
//   unit_result_input           packed result data, slice u = [u*OW +: OW]
//   write_back_output           one-cycle write-back strobe
//   write_back_register_output  destination of the current write-back
//   result_output               data of the current write-back
//   pending_output              at least one FIFO is non-empty (registered)
// -----------------------------------------------------------------------------
module write_back_arbiter #(
   parameter int  NUM_UNITS                 = 4,
   parameter int  FIFO_DEPTH                = 2,
   // Register-file geometry; fixed by the register file, not tunable here.
   localparam int REGISTER_DESCRIPTOR_WIDTH = 5,
   localparam int OPERAND_WIDTH             = 32
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic [NUM_UNITS-1:0]                           unit_valid_input,
   output logic [NUM_UNITS-1:0]                           unit_ready_output,
   input  logic [NUM_UNITS*REGISTER_DESCRIPTOR_WIDTH-1:0] unit_register_input,
   input  logic [NUM_UNITS*OPERAND_WIDTH-1:0]             unit_result_input,
   output logic                                           write_back_output,
   output logic [REGISTER_DESCRIPTOR_WIDTH-1:0]           write_back_register_output,
   output logic [OPERAND_WIDTH-1:0]                       result_output,
   output logic                                           pending_output
);

   localparam int DW    = REGISTER_DESCRIPTOR_WIDTH;
   localparam int OW    = OPERAND_WIDTH;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int GNT_W = $clog2(NUM_UNITS);

   // Per-unit FIFO status and heads, gathered for the arbiter / output mux.
   logic [NUM_UNITS-1:0]          nonempty;
   logic [NUM_UNITS-1:0]          nonempty_next;
   logic [NUM_UNITS-1:0][DW-1:0]  head_desc;
   logic [NUM_UNITS-1:0][OW-1:0]  head_data;

   // Arbiter state and decision.
   logic [GNT_W-1:0]              last_grant_reg;
   logic [GNT_W-1:0]              grant_idx;
   logic                          grant_valid;

   // Output registers.
   logic                          write_back_reg;
   logic [DW-1:0]                 wb_desc_reg;
   logic [OW-1:0]                 wb_data_reg;
   logic                          pending_reg;

   // -------------------------------------------------------------------------
   // Per-unit FIFOs
   // -------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
         logic [DW-1:0]    desc_mem [FIFO_DEPTH];
         logic [OW-1:0]    data_mem [FIFO_DEPTH];
         logic [PTR_W-1:0] wr_ptr_reg;
         logic [PTR_W-1:0] rd_ptr_reg;
         logic [CNT_W-1:0] count_reg;
         logic [CNT_W-1:0] count_next;
         logic [DW-1:0]    in_desc;
         logic [OW-1:0]    in_data;
         logic             accept;
         logic             push;
         logic             pop;

         assign in_desc = unit_register_input[gi*DW +: DW];
         assign in_data = unit_result_input[gi*OW +: OW];

         // Ready depends only on the registered count, so a full FIFO stays
         // not-ready even in the cycle it is being popped.
         assign unit_ready_output[gi] = !rst && (count_reg != CNT_W'(FIFO_DEPTH));

         // Writes to the zero register are consumed but never stored.
         assign accept = unit_valid_input[gi] && unit_ready_output[gi];
         assign push   = accept && (in_desc != '0);
         assign pop    = grant_valid && (grant_idx == GNT_W'(gi));

         assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

         assign nonempty[gi]      = (count_reg != '0);
         assign nonempty_next[gi] = (count_next != '0);
         assign head_desc[gi]     = desc_mem[rd_ptr_reg];
         assign head_data[gi]     = data_mem[rd_ptr_reg];

         // Storage carries no reset; validity is tracked by the count alone.
         always_ff @(posedge clk) begin
            if (push) begin
               desc_mem[wr_ptr_reg] <= in_desc;
               data_mem[wr_ptr_reg] <= in_data;
            end
         end

         // Pointers wrap naturally because FIFO_DEPTH is a power of two.
         always_ff @(posedge clk) begin
            if (rst) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
            end else begin
               if (push) begin
                  wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
               end
               if (pop) begin
                  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
               end
               count_reg <= count_next;
            end
         end
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Round-robin arbiter: first non-empty FIFO searching upward from
   // last_grant+1. Scanning offsets from farthest to nearest and letting later
   // hits overwrite earlier ones leaves the nearest candidate as the winner.
   // -------------------------------------------------------------------------
   always_comb begin : arbiter
      int idx;
      idx         = 0;
      grant_valid = 1'b0;
      grant_idx   = last_grant_reg;
      for (int i = NUM_UNITS; i >= 1; i--) begin
         idx = int'(last_grant_reg) + i;
         if (idx >= NUM_UNITS) begin
            idx = idx - NUM_UNITS;
         end
         if (nonempty[GNT_W'(idx)]) begin
            grant_valid = 1'b1;
            grant_idx   = GNT_W'(idx);
         end
      end
   end

   // -------------------------------------------------------------------------
   // Output register and grant pointer
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_reg <= GNT_W'(NUM_UNITS - 1);
         write_back_reg <= 1'b0;
         wb_desc_reg    <= '0;
         wb_data_reg    <= '0;
         pending_reg    <= 1'b0;
      end else begin
         write_back_reg <= grant_valid;
         pending_reg    <= |nonempty_next;
         if (grant_valid) begin
            last_grant_reg <= grant_idx;
            wb_desc_reg    <= head_desc[grant_idx];
            wb_data_reg    <= head_data[grant_idx];
         end
      end
   end

   assign write_back_output          = write_back_reg;
   assign write_back_register_output = wb_desc_reg;
   assign result_output              = wb_data_reg;
   assign pending_output             = pending_reg;

endmodule

// File: tb/tb_write_back_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for write_back_arbiter: a table of directed vectors, hand-written
// multi-cycle sequences and randomized traffic, all compared every cycle
// against a queue-based reference model of the write-back behaviour.
// -----------------------------------------------------------------------------
module tb_write_back_arbiter;
   localparam int NU    = 4;
   localparam int DEPTH = 2;
   localparam int DW    = 5;
   localparam int OW    = 32;

   logic               clk = 1'b0;
   logic               rst;
   logic [NU-1:0]      unit_valid_input;
   logic [NU-1:0]      unit_ready_output;
   logic [NU*DW-1:0]   unit_register_input;
   logic [NU*OW-1:0]   unit_result_input;
   logic               write_back_output;
   logic [DW-1:0]      write_back_register_output;
   logic [OW-1:0]      result_output;
   logic               pending_output;

   always #5 clk = ~clk;

   write_back_arbiter #(.NUM_UNITS(NU), .FIFO_DEPTH(DEPTH)) dut (
      .clk                        (clk),
      .rst                        (rst),
      .unit_valid_input           (unit_valid_input),
      .unit_ready_output          (unit_ready_output),
      .unit_register_input        (unit_register_input),
      .unit_result_input          (unit_result_input),
      .write_back_output          (write_back_output),
      .write_back_register_output (write_back_register_output),
      .result_output              (result_output),
      .pending_output             (pending_output)
   );

   int checks   = 0;
   int failures = 0;
   int cycle    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model: one queue per unit ----------------
   logic [DW-1:0] mq_reg [NU][$];
   logic [OW-1:0] mq_dat [NU][$];
   int            m_last = NU - 1;
   logic          m_wb   = 1'b0;
   logic [DW-1:0] m_wreg = '0;
   logic [OW-1:0] m_wdat = '0;
   logic          m_pend = 1'b0;

   function automatic logic [NU-1:0] m_ready(input logic r);
      logic [NU-1:0] rd;
      for (int u = 0; u < NU; u++) rd[u] = !r && (mq_reg[u].size() < DEPTH);
      return rd;
   endfunction

   task automatic model_edge(input logic r, input logic [NU-1:0] v,
                             input logic [NU*DW-1:0] regs, input logic [NU*OW-1:0] dat);
      logic [NU-1:0] rd;
      int g;
      if (r) begin
         for (int u = 0; u < NU; u++) begin
            mq_reg[u].delete();
            mq_dat[u].delete();
         end
         m_last = NU - 1;
         m_wb = 1'b0; m_wreg = '0; m_wdat = '0; m_pend = 1'b0;
         return;
      end
      rd = m_ready(1'b0);
      g = -1;
      for (int k = 1; k <= NU; k++) begin
         int u = (m_last + k) % NU;
         if (g < 0 && mq_reg[u].size() > 0) g = u;
      end
      if (g >= 0) begin
         m_wb   = 1'b1;
         m_wreg = mq_reg[g].pop_front();
         m_wdat = mq_dat[g].pop_front();
         m_last = g;
      end else begin
         m_wb = 1'b0;
      end
      for (int u = 0; u < NU; u++) begin
         if (v[u] && rd[u] && regs[u*DW +: DW] != '0) begin
            mq_reg[u].push_back(regs[u*DW +: DW]);
            mq_dat[u].push_back(dat[u*OW +: OW]);
         end
      end
      m_pend = 1'b0;
      for (int u = 0; u < NU; u++) if (mq_reg[u].size() > 0) m_pend = 1'b1;
   endtask

   // Observed write-backs (for sequence-level checks).
   int log_reg[$];
   int log_dat[$];
   int log_cyc[$];

   // One clock cycle: drive, check ready, clock, check registered outputs.
   task automatic step(input logic r, input logic [NU-1:0] v,
                       input logic [NU*DW-1:0] regs, input logic [NU*OW-1:0] dat,
                       output logic [NU-1:0] rdy_seen);
      rst = r; unit_valid_input = v; unit_register_input = regs; unit_result_input = dat;
      #1;
      rdy_seen = unit_ready_output;
      chk("ready", 32'(unit_ready_output), 32'(m_ready(r)));
      @(posedge clk);
      model_edge(r, v, regs, dat);
      #1;
      cycle++;
      chk("wb_strobe", 32'(write_back_output), 32'(m_wb));
      chk("wb_reg", 32'(write_back_register_output), 32'(m_wreg));
      chk("wb_data", result_output, m_wdat);
      chk("pending", 32'(pending_output), 32'(m_pend));
      if (write_back_output) begin
         log_reg.push_back(int'(write_back_register_output));
         log_dat.push_back(int'(result_output));
         log_cyc.push_back(cycle);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct packed {
      logic          r;
      logic [NU-1:0] v;
      logic [19:0]   regs;
      logic [127:0]  dat;
      logic [NU-1:0] exp_rdy;
      logic          exp_wb;
      logic [DW-1:0] exp_reg;
      logic [OW-1:0] exp_dat;
      logic          exp_pend;
   } vec_t;

   vec_t tbl [14];

   initial begin
      logic [NU-1:0] rdy;
      int n0, n3, seen_lo, seen_hi, k6, k7, cnt;

      rst = 1'b1; unit_valid_input = '0; unit_register_input = '0; unit_result_input = '0;

      //             r  v     regs                             dat                                          rdy   wb reg   dat       pend
      tbl[0]  = '{1'b1, 4'h0, 20'h0,                           128'h0,                                      4'h0, 1'b0, 5'd0, 32'h00, 1'b0};
      tbl[1]  = '{1'b0, 4'h2, {5'd0, 5'd0, 5'd3, 5'd0},        {32'h0, 32'h0, 32'hA5, 32'h0},              4'hF, 1'b0, 5'd0, 32'h00, 1'b1};
      tbl[2]  = '{1'b0, 4'h0, 20'h0,                           128'h0,                                      4'hF, 1'b1, 5'd3, 32'hA5, 1'b0};
      tbl[3]  = '{1'b0, 4'h0, 20'h0,                           128'h0,                                      4'hF, 1'b0, 5'd3, 32'hA5, 1'b0};
      tbl[4]  = '{1'b1, 4'h0, 20'h0,                           128'h0,                                      4'h0, 1'b0, 5'd0, 32'h00, 1'b0};
      tbl[5]  = '{1'b0, 4'hF, {5'd4, 5'd3, 5'd2, 5'd1},        {32'h13, 32'h12, 32'h11, 32'h10},           4'hF, 1'b0, 5'd0, 32'h00, 1'b1};
      tbl[6]  = '{1'b0, 4'h0, 20'h0,                           128'h0,                                      4'hF, 1'b1, 5'd1, 32'h10, 1'b1};
      tbl[7]  = '{1'b0, 4'h0, 20'h0,                           128'h0,                                      4'hF, 1'b1, 5'd2, 32'h11, 1'b1};
      tbl[8]  = '{1'b0, 4'h0, 20'h0,                           128'h0,                                      4'hF, 1'b1, 5'd3, 32'h12, 1'b1};
      tbl[9]  = '{1'b0, 4'h0, 20'h0,                           128'h0,                                      4'hF, 1'b1, 5'd4, 32'h13, 1'b0};
      tbl[10] = '{1'b0, 4'h0, 20'h0,                           128'h0,                                      4'hF, 1'b0, 5'd4, 32'h13, 1'b0};
      tbl[11] = '{1'b0, 4'h1, 20'h0,                           {32'h0, 32'h0, 32'h0, 32'hFF},              4'hF, 1'b0, 5'd4, 32'h13, 1'b0};
      tbl[12] = '{1'b0, 4'h0, 20'h0,                           128'h0,                                      4'hF, 1'b0, 5'd4, 32'h13, 1'b0};
      tbl[13] = '{1'b0, 4'h0, 20'h0,                           128'h0,                                      4'hF, 1'b0, 5'd4, 32'h13, 1'b0};

      for (int i = 0; i < 14; i++) begin
         step(tbl[i].r, tbl[i].v, tbl[i].regs, tbl[i].dat, rdy);
         chk($sformatf("tbl%0d_ready", i), 32'(rdy), 32'(tbl[i].exp_rdy));
         chk($sformatf("tbl%0d_wb", i), 32'(write_back_output), 32'(tbl[i].exp_wb));
         chk($sformatf("tbl%0d_reg", i), 32'(write_back_register_output), 32'(tbl[i].exp_reg));
         chk($sformatf("tbl%0d_data", i), result_output, tbl[i].exp_dat);
         chk($sformatf("tbl%0d_pending", i), 32'(pending_output), 32'(tbl[i].exp_pend));
         $display("vec %0d: rst=%0b valid=%h ready=%h wb=%0b reg=%0d data=%h pend=%0b",
                  i, tbl[i].r, tbl[i].v, rdy, write_back_output,
                  write_back_register_output, result_output, pending_output);
      end

      // ---- unit 2 streams six results at full rate ----
      step(1'b1, 4'h0, '0, '0, rdy);
      log_reg.delete(); log_dat.delete(); log_cyc.delete();
      for (int i = 1; i <= 6; i++) begin
         step(1'b0, 4'h4, {5'd0, 5'd5, 5'd0, 5'd0}, {32'h0, 32'(i), 32'h0, 32'h0}, rdy);
         chk("stream_u2_ready", 32'(rdy[2]), 32'd1);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 4'h0, '0, '0, rdy);
      chk("stream_count", 32'(log_reg.size()), 32'd6);
      for (int i = 0; i < log_reg.size() && i < 6; i++) begin
         chk($sformatf("stream_data%0d", i), 32'(log_dat[i]), 32'(i + 1));
         if (i > 0) chk($sformatf("stream_gap%0d", i), 32'(log_cyc[i] - log_cyc[i-1]), 32'd1);
      end
      $display("stream: %0d write-backs observed", log_reg.size());

      // ---- units 0 and 3 under continuous contention ----
      step(1'b1, 4'h0, '0, '0, rdy);
      log_reg.delete(); log_dat.delete(); log_cyc.delete();
      n0 = 0; n3 = 0; seen_lo = 0; seen_hi = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 4'h9, {5'd7, 5'd0, 5'd0, 5'd6},
              {32'h300 + 32'(n3), 32'h0, 32'h0, 32'h100 + 32'(n0)}, rdy);
         if (rdy[0]) begin n0++; seen_hi = 1; end else seen_lo = 1;
         if (rdy[3]) n3++;
      end
      for (int i = 0; i < 6; i++) step(1'b0, 4'h0, '0, '0, rdy);
      chk("contend_u0_ready_toggles", 32'(seen_lo & seen_hi), 32'd1);
      k6 = 0; k7 = 0;
      for (int i = 0; i < log_reg.size(); i++) begin
         if (log_reg[i] == 6) begin
            chk($sformatf("contend_u0_data%0d", k6), 32'(log_dat[i]), 32'h100 + 32'(k6));
            k6++;
         end else begin
            chk($sformatf("contend_u3_data%0d", k7), 32'(log_dat[i]), 32'h300 + 32'(k7));
            k7++;
         end
         if (i < 6) chk($sformatf("contend_alt%0d", i), 32'(log_reg[i]), (i % 2 == 0) ? 32'd6 : 32'd7);
      end
      chk("contend_u0_total", 32'(k6), 32'(n0));
      chk("contend_u3_total", 32'(k7), 32'(n3));
      $display("contend: u0 accepted=%0d written=%0d, u3 accepted=%0d written=%0d", n0, k6, n3, k7);

      // ---- reset while unit 1 holds two buffered entries ----
      step(1'b1, 4'h0, '0, '0, rdy);
      log_reg.delete(); log_dat.delete(); log_cyc.delete();
      step(1'b0, 4'h3, {5'd0, 5'd0, 5'd10, 5'd9}, {32'h0, 32'h0, 32'hB1, 32'hA1}, rdy);
      step(1'b0, 4'h3, {5'd0, 5'd0, 5'd10, 5'd9}, {32'h0, 32'h0, 32'hB2, 32'hA2}, rdy);
      step(1'b1, 4'h0, '0, '0, rdy);
      chk("rstmid_ready_during_rst", 32'(rdy), 32'h0);
      chk("rstmid_wb", 32'(write_back_output), 32'd0);
      chk("rstmid_pending", 32'(pending_output), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 4'h0, '0, '0, rdy);
         chk("rstmid_ready_after", 32'(rdy), 32'hF);
         chk("rstmid_no_wb", 32'(write_back_output), 32'd0);
      end
      cnt = 0;
      foreach (log_reg[i]) if (log_reg[i] == 10) cnt++;
      chk("rstmid_u1_never_written", 32'(cnt), 32'd0);
      $display("rstmid: write-backs after flush=%0d", cnt);

      // ---- randomized traffic against the model ----
      step(1'b1, 4'h0, '0, '0, rdy);
      for (int i = 0; i < 400; i++) begin
         logic r;
         r = ($urandom_range(0, 59) == 0);
         step(r, 4'($urandom), 20'($urandom),
              {$urandom, $urandom, $urandom, $urandom}, rdy);
         $display("rand %0d: rst=%0b valid=%h ready=%h wb=%0b reg=%0d data=%h pend=%0b",
                  i, r, unit_valid_input, rdy, write_back_output,
                  write_back_register_output, result_output, pending_output);
      end
      for (int i = 0; i < 10; i++) step(1'b0, 4'h0, '0, '0, rdy);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
